uart_out: RTL

Output stage for the tiny16 CPU. It samples the 16-bit system bus when the controller strobes an output write and queues the word in a small FIFO. Each queued word is then sent over a UART TX line as two 8N1 bytes, low byte first. It sits directly downstream of the bus (`OUT`) and is the CPU's only host-visible output besides the raw bus pins.

---
 rtl/uart_out.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_out.sv
// uart_out: output stage for the tiny16 CPU.
//
// Captures the 16-bit system bus on an output-write strobe into a small FIFO.
// Each queued word goes out on a UART TX line as two bytes, low byte first.
// The frame format is 8N1, or 8E1 when UART_OUT_PARITY_EN is defined.
//
// Parameters:
//   CLK_HZ  clock frequency in Hz
//   BAUD    line rate; bit period DIV = CLK_HZ / BAUD (truncated, >= 2)
//   DEPTH   FIFO depth in words (power of 2, >= 2)
//
// Ports:
//   clk     system clock (single domain)
//   rst     synchronous active-high reset
//   in_en   write strobe; the bus word is captured on the rising edge
//   in      16-bit bus value
//   last    most recently accepted word (LED/debug display)
//   full    FIFO holds DEPTH words
//   busy    FIFO non-empty or a frame in progress
//   ovf     sticky: a write was dropped because the FIFO was full
//   tx      UART serial line, idles high
//
// Build option:
//   UART_OUT_PARITY_EN  adds an even-parity bit after the data bits (8E1)

module uart_out #(
    parameter int unsigned CLK_HZ = 16000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_en,
    input  logic [15:0] in,
    output logic [15:0] last,
    output logic        full,
    output logic        busy,
    output logic        ovf,
    output logic        tx
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned PW  = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef UART_OUT_PARITY_EN
        ,
        S_PARITY
`endif
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          push;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // full is taken from the pre-edge state: a word arriving while full is
    // dropped even if the transmitter frees a slot on the same edge.
    assign push = in_en && !full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            last   <= '0;
            ovf    <= 1'b0;
        end else if (in_en) begin
            if (full) begin
                ovf <= 1'b1;
            end else begin
                wr_ptr <= wr_ptr + PW'(1);
                last   <= in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t        state;
    logic [CW-1:0] cnt;
    logic          cnt_last;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_nxt;
    logic          byte_idx;
    logic [7:0]    bdata;
    logic [7:0]    hold_hi;

    assign cnt_last = (cnt == CW'(DIV - 1));
    assign bit_nxt  = bit_idx + 3'd1;
    assign busy     = !empty || (state != S_IDLE);

    // tx is registered and loaded with the level of the state being entered,
    // so the line changes on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= 1'b0;
            bdata    <= '0;
            hold_hi  <= '0;
            rd_ptr   <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    tx  <= 1'b1;
                    if (!empty) begin
                        bdata    <= mem[rd_ptr[AW-1:0]][7:0];
                        hold_hi  <= mem[rd_ptr[AW-1:0]][15:8];
                        byte_idx <= 1'b0;
                        rd_ptr   <= rd_ptr + PW'(1);
                        tx       <= 1'b0;
                        state    <= S_START;
                    end
                end

                S_START: begin
                    if (cnt_last) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx      <= bdata[0];
                        state   <= S_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_DATA: begin
                    if (cnt_last) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_OUT_PARITY_EN
                            tx    <= ^bdata;
                            state <= S_PARITY;
`else
                            tx    <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_nxt;
                            tx      <= bdata[bit_nxt];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

`ifdef UART_OUT_PARITY_EN
                S_PARITY: begin
                    if (cnt_last) begin
                        cnt   <= '0;
                        tx    <= 1'b1;
                        state <= S_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif

                S_STOP: begin
                    if (cnt_last) begin
                        cnt <= '0;
                        if (!byte_idx) begin
                            // High byte follows immediately, no idle gap.
                            byte_idx <= 1'b1;
                            bdata    <= hold_hi;
                            tx       <= 1'b0;
                            state    <= S_START;
                        end else begin
                            tx    <= 1'b1;
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                default: begin
                    cnt   <= '0;
                    tx    <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
